pdm_deserializer: RTL and testbench

Parametrised successor to the single-channel 16-bit PDM deserializer. It generates the PDM microphone clock from the system clock with a programmable divider. It captures one or two interleaved PDM channels (left and right on opposite microphone clock edges) into WORD_W-bit words, MSB first. Completed words are buffered in a small FIFO with a valid/ready output, so the downstream filter/audio path can apply backpressure without losing words.

---
 rtl/pdm_deserializer.sv | 81 ++++++++
 tb/tb_pdm_deserializer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pdm_deserializer.sv
// pdm_deserializer: PDM mic clock generator with mono/stereo MSB-first word capture
// and a valid/ready output FIFO with sticky overflow.
module pdm_deserializer #(
  parameter int CLK_DIV    = 50,
  parameter int WORD_W     = 16,
  parameter int STEREO     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              data_in,
  output logic              pdm_clk_o,
  output logic              pdm_irsel_o,
  output logic              word_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_chan,
  output logic              overflow
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WORD_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DW-1:0]     div_cnt;
  logic [WORD_W-1:0] sr [2];
  logic [BW-1:0]     bit_cnt [2];
  logic [WORD_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              toggle, chan, sample, push, pop, full, wr;
  logic [WORD_W:0]   head;
  assign toggle      = enable && div_cnt == DW'(CLK_DIV - 1);
  // pdm_clk_o low before the toggle means a rising edge follows: right channel slot
  assign chan        = !pdm_clk_o;
  assign sample      = toggle && (pdm_clk_o || STEREO != 0);
  assign push        = sample && bit_cnt[chan] == BW'(WORD_W - 1);
  assign pop         = out_valid && out_ready;
  assign full        = count == (AW+1)'(FIFO_DEPTH);
  assign wr          = push && (!full || pop);
  assign out_valid   = count != '0;
  // when empty, the slot just behind the read pointer is the last word shown
  assign head        = out_valid ? mem[rd_ptr] : mem[rd_ptr - AW'(1)];
  assign out_chan    = head[WORD_W];
  assign out_data    = head[WORD_W-1:0];
  assign pdm_irsel_o = 1'b0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      div_cnt   <= '0;
      pdm_clk_o <= 1'b0;
    end else begin
      div_cnt   <= (!enable || toggle) ? '0 : div_cnt + 1'b1;
      pdm_clk_o <= enable && (pdm_clk_o ^ toggle);
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n || !enable) begin
      sr      <= '{default: '0};
      bit_cnt <= '{default: '0};
    end else if (sample) begin
      sr[chan]      <= {sr[chan][WORD_W-2:0], data_in};
      bit_cnt[chan] <= push ? '0 : bit_cnt[chan] + 1'b1;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mem       <= '{default: '0};
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      word_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      word_done <= push;
      overflow  <= enable && (overflow || (push && !wr));
      if (wr) begin
        mem[wr_ptr] <= {chan, sr[chan][WORD_W-2:0], data_in};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    end
endmodule

// File: tb/tb_pdm_deserializer.sv
// tb_pdm_deserializer: stereo 8-bit capture checked every cycle against a queue-based
// model, plus literal checks for reset, overflow, drain order and async reset.
module tb_pdm_deserializer;
  localparam int CD = 3, W = 8, ST = 1, D = 4;
  logic clock = 0, reset_n = 0, enable = 0, din_r = 0, follow = 0, out_ready = 0;
  logic data_in, pdm_clk_o, pdm_irsel_o, word_done, out_valid, out_chan, overflow;
  logic [W-1:0] out_data;
  int tests = 0, fails = 0, t = 0;
  bit ql[$], qr[$];
  logic [W:0] fq[$];
  logic [W:0] m_head = '0;
  logic m_wd = 0, m_ovf = 0;
  logic [W:0] lit [4] = '{9'h100, 9'h0FF, 9'h100, 9'h0FF};

  assign data_in = follow ? pdm_clk_o : din_r;

  pdm_deserializer #(.CLK_DIV(CD), .WORD_W(W), .STEREO(ST), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(data_in),
    .pdm_clk_o(pdm_clk_o), .pdm_irsel_o(pdm_irsel_o), .word_done(word_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .overflow(overflow));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit q[$]);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) w[W-1-i] = q[i];
    return w;
  endfunction

  // t = enabled clock edges since enable rose; toggle n happens at t = n*CD,
  // odd n are rising edges (right slot), even n falling edges (left slot)
  always @(posedge clock or negedge reset_n) begin : model
    logic [W:0] nw;
    bit np, pop;
    if (!reset_n) begin
      t = 0; ql.delete(); qr.delete(); fq.delete(); m_head = '0; m_wd = 0; m_ovf = 0;
    end else begin
      np = 0;
      nw = '0;
      pop = fq.size() > 0 && out_ready;
      if (!enable) begin
        t = 0; ql.delete(); qr.delete(); m_ovf = 0;
      end else begin
        t++;
        if (t % CD == 0) begin
          if ((t / CD) % 2 == 0) begin
            ql.push_back(data_in);
            if (ql.size() == W) begin nw = {1'b0, pack(ql)}; np = 1; ql.delete(); end
          end else if (ST != 0) begin
            qr.push_back(data_in);
            if (qr.size() == W) begin nw = {1'b1, pack(qr)}; np = 1; qr.delete(); end
          end
        end
      end
      if (pop) void'(fq.pop_front());
      if (np) begin
        if (fq.size() < D) fq.push_back(nw);
        else m_ovf = 1;
      end
      m_wd = np;
      if (fq.size() > 0) m_head = fq[0];
    end
  end

  always @(negedge clock) if (reset_n) begin
    chk("pdm_clk", pdm_clk_o, (t / CD) % 2);
    chk("irsel", pdm_irsel_o, 0);
    chk("word_done", word_done, m_wd);
    chk("out_valid", out_valid, fq.size() > 0);
    chk("head", {out_chan, out_data}, m_head);
    chk("overflow", overflow, m_ovf);
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_pdm_clk", pdm_clk_o, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_head", {out_chan, out_data}, 0);
    chk("rst_word_done", word_done, 0);
    chk("rst_overflow", overflow, 0);
    #1 reset_n = 1; enable = 1; follow = 1;
    // right completes at t=45,93,141; left at t=48,96,144: 5th and 6th words drop
    repeat (150) @(negedge clock);
    chk("lit_ovf_set", overflow, 1);
    chk("lit_full_valid", out_valid, 1);
    #1 enable = 0;
    @(negedge clock);
    chk("lit_ovf_clr", overflow, 0);
    chk("lit_pdm_off", pdm_clk_o, 0);
    for (int i = 0; i < 4; i++) begin
      chk("lit_drain_head", {out_chan, out_data}, lit[i]);
      chk("lit_drain_valid", out_valid, 1);
      #1 out_ready = 1;
      @(negedge clock);
    end
    chk("lit_empty", out_valid, 0);
    chk("lit_hold_head", {out_chan, out_data}, 9'h0FF);
    #1 follow = 0; enable = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      #1 din_r = 1'($urandom);
      out_ready = ($urandom_range(99) < (((i / 400) % 2) ? 15 : 85));
      if ($urandom_range(599) == 0) enable = 0;
      else if (!enable && $urandom_range(9) == 0) enable = 1;
    end
    #1 enable = 1; follow = 1; out_ready = 0;
    repeat (140) @(negedge clock);
    #2 reset_n = 0;
    #1;
    chk("arst_pdm_clk", pdm_clk_o, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_head", {out_chan, out_data}, 0);
    chk("arst_word_done", word_done, 0);
    chk("arst_overflow", overflow, 0);
    @(negedge clock);
    #1 reset_n = 1;
    repeat (60) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
